// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
// The pipeline side is the master; the divider is the slave.
interface div_unit_if;
  logic        start;
  logic        signed_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  modport master (
    output start, signed_op, A, B, cancel,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, signed_op, A, B, cancel,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Signed operands are reduced to magnitudes on acceptance and the signs are
// re-applied in the final FIX cycle, so the core loop is purely unsigned.
module div_unit (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        sign_q;
  logic        sign_r;
  logic        dbz;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [4:0]  count;

  logic [63:0] result_q;
  logic        done_q;
  logic        dbz_q;

  logic        accept;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] trial;
  logic [32:0] shifted;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept  = (state == IDLE) && bus.start && !bus.cancel;
  assign b_zero  = (bus.B == 32'h0);
  assign abs_a   = (bus.signed_op && bus.A[31]) ? -bus.A : bus.A;
  assign abs_b   = (bus.signed_op && bus.B[31]) ? -bus.B : bus.B;

  // The dividend's top bit moves into the remainder each step; the trial
  // difference is one bit wider than the operands so its MSB is the borrow.
  assign shifted = {rem[31:0], dvd[31]};
  assign trial   = {rem, dvd[31]} - {2'b00, dvs};

  // After the last step the dividend register has become the quotient.
  assign q_fix   = sign_q ? -dvd : dvd;
  assign r_fix   = sign_r ? -rem[31:0] : rem[31:0];

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: cancel always wins and returns to IDLE without a result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = b_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (count == 5'd0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, the shift/subtract loop and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dbz      <= 1'b0;
      dvd      <= 32'h0;
      dvs      <= 32'h0;
      rem      <= 33'h0;
      count    <= 5'd0;
      result_q <= 64'h0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= bus.signed_op & (bus.A[31] ^ bus.B[31]);
            sign_r <= bus.signed_op & bus.A[31];
            dbz    <= b_zero;
            dvd    <= b_zero ? bus.A : abs_a;
            dvs    <= abs_b;
            rem    <= 33'h0;
            count  <= 5'd31;
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            if (trial[33]) begin
              rem <= shifted;
              dvd <= {dvd[30:0], 1'b0};
            end else begin
              rem <= trial[32:0];
              dvd <= {dvd[30:0], 1'b1};
            end
            count <= count - 5'd1;
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            done_q   <= 1'b1;
            dbz_q    <= dbz;
            result_q <= dbz ? {32'hFFFF_FFFF, dvd} : {q_fix, r_fix};
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage. It sits beside the combinational ALU and takes the same A/B operands from the register-read stage. It produces the 64-bit {quotient, remainder} word that the ALU's divide opcodes leave unimplemented. Restoring, radix-2, one quotient bit per cycle, with a start/busy/done handshake so the pipeline can stall on it.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only on a clock edge where busy=0 and cancel=0
- signed_op  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
- A  in  32  dividend; sampled with start
- B  in  32  divisor; sampled with start
- cancel  in  1  pipeline flush; aborts any operation in progress
- busy  out  1  operation in progress; new starts ignored
- done  out  1  one-cycle pulse, result valid
- result  out  64  {quotient[31:0], remainder[31:0]}; held until the next done
- div_by_zero  out  1  set with done when B==0; held with result

## Operation
- States: IDLE, CALC, FIX.
- IDLE + accepted start:
  - Latch sign_q = signed_op & (A[31]^B[31]) and sign_r = signed_op & A[31].
  - Latch magnitudes |A|, |B|; in unsigned mode the raw values are used.
  - Clear the 33-bit partial remainder and set count=31.
  - busy goes to 1. Next state is CALC, or FIX directly if B==0.
- CALC, one step per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem[32:0]. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement count. After the count==0 step, go to FIX. That is 32 CALC cycles.
- FIX:
  - Quotient is negated if sign_q; remainder is negated if sign_r.
  - result is registered, done=1 for this one edge's output cycle, busy=0, next state IDLE.
- Divide by zero: result = {32'hFFFFFFFF, A} with raw A, no sign fixing, and div_by_zero=1. Otherwise div_by_zero=0 at done.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - Magnitude quotient 0x80000000 is not negated because sign_q=0, giving quotient 0x80000000 and remainder 0.
  - No trap is raised.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- start while busy: ignored, with no effect on the operation in flight.
- cancel:
  - In CALC or FIX, the next state is IDLE and busy=0 after that edge.
  - done is not asserted, and result and div_by_zero keep their previous values.
  - cancel with start in IDLE: start is ignored.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=64'h0, div_by_zero=0, all internal registers cleared. Reset mid-operation discards it with no done.
- start accepted at edge E0 → busy=1 after E0, CALC on E1..E32, FIX on E33.
- After E33: done=1 and result valid for exactly one cycle; busy=0. Latency is 33 edges from acceptance.
- B==0: FIX on E1, so done is visible after E1.
- A new start may be accepted in the same cycle done is high (busy=0). The next done follows 33 edges later.
- done is never high on two consecutive cycles.

## Test plan
- Unsigned A=100, B=7 → done 33 edges after start; result={32'd14, 32'd2}; div_by_zero=0.
- Signed A=-7 (0xFFFFFFF9), B=2 → result={32'hFFFFFFFD, 32'hFFFFFFFF}. Same operands unsigned → {32'h7FFFFFFC, 32'h1}.
- Signed 0x80000000 / 0xFFFFFFFF → {32'h80000000, 32'h0}. Unsigned 0xFFFFFFFF / 0x1 → {32'hFFFFFFFF, 0}.
- B=0, A=0x1234 → done after 1 edge; result={32'hFFFFFFFF, 32'h1234}; div_by_zero=1.
- start pulsed at cycle 10 of an operation → ignored and the original result is correct. cancel at cycle 15 → busy=0 next cycle, no done, result unchanged from the previous op.
- Assert rst_n=0 asynchronously mid-CALC → busy, done and result go to 0 immediately. A fresh 100/7 after release completes normally.
